ps2_multi_dir_decoder: RTL and testbench

Parametrised successor to the single-player inline PS/2 direction decoder. It turns the byte stream from ps2_keyboard into per-player direction registers and one-cycle change pulses. It supports NUM_PLAYERS independent key maps, E0-extended scancodes (arrow keys), break-code suppression, held-key tracking and 180° reversal rejection. It sits between ps2_keyboard and game_logic and runs on the 50 MHz system clock.

---
 rtl/ps2_multi_dir_decoder.sv | 172 +++++++++++++++++
 tb/tb_ps2_multi_dir_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_multi_dir_decoder.sv
// ps2_multi_dir_decoder: turns the ps2_keyboard byte stream into per-player
// direction registers, change pulses and held-key flags for game_logic.
//
// Ports:
//   clock        in   system clock (CLOCK_50 domain)
//   reset_n      in   asynchronous active-low reset
//   ps2_code_new in   one-cycle strobe, ps2_code valid
//   ps2_code     in   received scancode byte
//   enable       in   1 = direction updates allowed
//   restart      in   synchronous reload of INIT_DIR, clears held keys
//   dir          out  per-player direction, UP=0 DOWN=1 LEFT=2 RIGHT=3
//   dir_change   out  one-cycle pulse per player on a direction change
//   key_held     out  per-key held flags, bit 4p+3 = UP .. bit 4p = RIGHT
//   unknown_key  out  one-cycle pulse when a make code matches no key
module ps2_multi_dir_decoder #(
    parameter int                         NUM_PLAYERS    = 2,
    parameter logic [32*NUM_PLAYERS-1:0]  KEYMAP         =
        {8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23},
    parameter logic [4*NUM_PLAYERS-1:0]   EXTMASK        = 8'b1111_0000,
    parameter logic [2*NUM_PLAYERS-1:0]   INIT_DIR       = {2'd0, 2'd3},
    parameter bit                         REJECT_REVERSE = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ps2_code_new,
    input  logic [7:0]                 ps2_code,
    input  logic                       enable,
    input  logic                       restart,
    output logic [2*NUM_PLAYERS-1:0]   dir,
    output logic [NUM_PLAYERS-1:0]     dir_change,
    output logic [4*NUM_PLAYERS-1:0]   key_held,
    output logic                       unknown_key
);

    localparam int NK = 4 * NUM_PLAYERS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     is_make;
    logic                     is_brk;
    logic                     ext;
    logic                     byte_ignored;
    logic [NK-1:0]            hit;
    logic [NK-1:0]            held_nxt;
    logic [2*NUM_PLAYERS-1:0] dir_nxt;
    logic [NUM_PLAYERS-1:0]   chg_nxt;
    logic                     unknown_nxt;

    // Keyboard housekeeping bytes (ACK, BAT, echo, resend, errors) and the
    // Pause prefix never reach the key decoder.
    always_comb begin
        byte_ignored = (ps2_code == 8'hFA) || (ps2_code == 8'hAA) ||
                       (ps2_code == 8'hEE) || (ps2_code == 8'hFE) ||
                       (ps2_code == 8'h00) || (ps2_code == 8'hFF) ||
                       (ps2_code == 8'hE1);
    end

    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_brk    = 1'b0;
        ext       = 1'b0;
        if (ps2_code_new) begin
            unique case (state)
                S_IDLE: begin
                    unique case (1'b1)
                        (ps2_code == 8'hE0): state_nxt = S_EXT;
                        (ps2_code == 8'hF0): state_nxt = S_BRK;
                        byte_ignored:        state_nxt = S_IDLE;
                        default:             is_make   = 1'b1;
                    endcase
                end
                S_EXT: begin
                    unique case (1'b1)
                        (ps2_code == 8'hF0): state_nxt = S_EXT_BRK;
                        (ps2_code == 8'hE0): state_nxt = S_EXT;
                        default: begin
                            is_make   = 1'b1;
                            ext       = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    endcase
                end
                S_BRK: begin
                    is_brk    = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    is_brk    = 1'b1;
                    ext       = 1'b1;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Key k of player p lives at KEYMAP byte 32p+31-8k and flag bit 4p+3-k.
    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int k = 0; k < 4; k++) begin
                hit[4*p+3-k] =
                    (ps2_code == KEYMAP[32*p+31-8*k -: 8]) &&
                    (ext == EXTMASK[4*p+3-k]);
            end
        end
    end

    always_comb begin
        held_nxt = key_held;
        if (is_make) begin
            held_nxt = key_held | hit;
        end else if (is_brk) begin
            held_nxt = key_held & ~hit;
        end
    end

    assign unknown_nxt = is_make && (hit == '0);

    always_comb begin
        logic [1:0] cand;
        logic [1:0] cur;
        logic       cand_vld;
        dir_nxt = dir;
        chg_nxt = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            cand     = 2'd0;
            cand_vld = 1'b0;
            // Descending scan so the lowest k (UP first) wins a duplicate map.
            for (int k = 3; k >= 0; k--) begin
                if (hit[4*p+3-k]) begin
                    cand     = 2'(k);
                    cand_vld = 1'b1;
                end
            end
            cur = dir[2*p +: 2];
            if (is_make && enable && cand_vld && (cand != cur) &&
                !(REJECT_REVERSE && (cand == (cur ^ 2'b01)))) begin
                dir_nxt[2*p +: 2] = cand;
                chg_nxt[p]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            dir         <= INIT_DIR;
            dir_change  <= '0;
            key_held    <= '0;
            unknown_key <= 1'b0;
        end else if (restart) begin
            state       <= S_IDLE;
            dir         <= INIT_DIR;
            dir_change  <= '0;
            key_held    <= '0;
            unknown_key <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            dir_change  <= chg_nxt;
            key_held    <= held_nxt;
            unknown_key <= unknown_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_multi_dir_decoder.sv
// tb_ps2_multi_dir_decoder: directed bench for ps2_multi_dir_decoder.
// Strobes scancode sequences and checks dir, pulses and held flags.
module tb_ps2_multi_dir_decoder;

    logic       clock;
    logic       reset_n;
    logic       ps2_code_new;
    logic [7:0] ps2_code;
    logic       enable;
    logic       restart;
    logic [3:0] dir;
    logic [1:0] dir_change;
    logic [7:0] key_held;
    logic       unknown_key;

    int passed = 0;
    int total  = 0;

    ps2_multi_dir_decoder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_code_new (ps2_code_new),
        .ps2_code     (ps2_code),
        .enable       (enable),
        .restart      (restart),
        .dir          (dir),
        .dir_change   (dir_change),
        .key_held     (key_held),
        .unknown_key  (unknown_key)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Strobe on a falling edge; outputs are registered by the following
    // rising edge and are read back on the next falling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        ps2_code     = b;
        ps2_code_new = 1'b1;
        @(negedge clock);
        ps2_code_new = 1'b0;
    endtask

    task automatic idle();
        @(negedge clock);
    endtask

    initial begin
        reset_n      = 1'b0;
        ps2_code_new = 1'b0;
        ps2_code     = 8'h00;
        enable       = 1'b1;
        restart      = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        idle();
        chk("rst_dir", dir, 4'h3);
        chk("rst_chg", dir_change, 2'b00);
        chk("rst_held", key_held, 8'h00);
        chk("rst_unk", unknown_key, 1'b0);

        // 1: W turns P0 RIGHT -> UP; break clears held
        send(8'h1D);
        chk("t1_dir", dir, 4'h0);
        chk("t1_chg", dir_change, 2'b01);
        chk("t1_held", key_held, 8'h08);
        chk("t1_unk", unknown_key, 1'b0);
        idle();
        chk("t1_chg_1cyc", dir_change, 2'b00);
        send(8'hF0);
        send(8'h1D);
        chk("t1_brk_held", key_held, 8'h00);
        chk("t1_brk_chg", dir_change, 2'b00);
        chk("t1_brk_dir", dir, 4'h0);

        // 2: arrows need E0; plain 75 is unknown
        send(8'hE0);
        chk("t2_e0_chg", dir_change, 2'b00);
        send(8'h6B);
        chk("t2_left_dir", dir, 4'h8);
        chk("t2_left_chg", dir_change, 2'b10);
        chk("t2_left_held", key_held, 8'h20);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        chk("t2_left_brk", key_held, 8'h00);
        send(8'hE0);
        send(8'h75);
        chk("t2_up_dir", dir, 4'h0);
        chk("t2_up_chg", dir_change, 2'b10);
        chk("t2_up_held", key_held, 8'h80);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("t2_up_brk", key_held, 8'h00);
        send(8'h75);
        chk("t2_plain_unk", unknown_key, 1'b1);
        chk("t2_plain_dir", dir, 4'h0);
        chk("t2_plain_chg", dir_change, 2'b00);
        idle();
        chk("t2_unk_1cyc", unknown_key, 1'b0);

        // 3: reversal rejected, typematic repeats silent
        send(8'h1B);
        chk("t3_rev_dir", dir, 4'h0);
        chk("t3_rev_chg", dir_change, 2'b00);
        chk("t3_rev_held", key_held, 8'h04);
        send(8'h1C);
        chk("t3_left_dir", dir, 4'h2);
        chk("t3_left_chg", dir_change, 2'b01);
        chk("t3_left_held", key_held, 8'h06);
        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            chk("t3_rep_chg", dir_change, 2'b00);
        end
        chk("t3_rep_dir", dir, 4'h2);
        send(8'hF0);
        send(8'h1B);
        send(8'hF0);
        send(8'h1C);
        chk("t3_brk_held", key_held, 8'h00);

        // 4: enable gates dir but not held tracking
        enable = 1'b0;
        send(8'h23);
        chk("t4_dis_dir", dir, 4'h2);
        chk("t4_dis_chg", dir_change, 2'b00);
        chk("t4_dis_held", key_held, 8'h01);
        enable = 1'b1;
        send(8'h23);
        chk("t4_rev_dir", dir, 4'h2);
        chk("t4_rev_chg", dir_change, 2'b00);
        send(8'h1D);
        chk("t4_up_dir", dir, 4'h0);
        send(8'h23);
        chk("t4_right_dir", dir, 4'h3);
        chk("t4_right_chg", dir_change, 2'b01);
        chk("t4_right_held", key_held, 8'h09);

        // 5: async reset after E0, then restart drops a strobe
        send(8'hE0);
        reset_n = 1'b0;
        #3;
        chk("t5_rst_dir", dir, 4'h3);
        chk("t5_rst_held", key_held, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        send(8'h6B);
        chk("t5_fresh_unk", unknown_key, 1'b1);
        chk("t5_fresh_dir", dir, 4'h3);
        send(8'h1D);
        chk("t5_up_dir", dir, 4'h0);
        chk("t5_up_held", key_held, 8'h08);
        @(negedge clock);
        restart      = 1'b1;
        ps2_code     = 8'h1D;
        ps2_code_new = 1'b1;
        @(negedge clock);
        restart      = 1'b0;
        ps2_code_new = 1'b0;
        chk("t5_rs_dir", dir, 4'h3);
        chk("t5_rs_chg", dir_change, 2'b00);
        chk("t5_rs_held", key_held, 8'h00);
        chk("t5_rs_unk", unknown_key, 1'b0);

        // 6: housekeeping bytes ignored, FSM stays IDLE
        send(8'hFA);
        chk("t6_fa_unk", unknown_key, 1'b0);
        send(8'hAA);
        chk("t6_aa_unk", unknown_key, 1'b0);
        send(8'hE1);
        chk("t6_e1_unk", unknown_key, 1'b0);
        chk("t6_dir", dir, 4'h3);
        chk("t6_held", key_held, 8'h00);
        send(8'h1B);
        chk("t6_down_dir", dir, 4'h1);
        chk("t6_down_chg", dir_change, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
